rvfi_check_sequencer: RTL
=========================

# rvfi_check_sequencer

Drives a riscv-formal check harness: it sequences the DUT reset and emits the `trig` and `check` strobes that checkers such as the hang check sample. It also runs a retire watchdog and a retire counter on the RVFI valid bus, so benches and covers can see progress without decoding RVFI themselves. It sits between the harness top level and the per-check modules, one instance per harness.

## Interface
Parameters:
- `NRET`, 1 — number of RVFI retire channels (matches `RISCV_FORMAL_NRET`).
- `RESET_CYCLES`, 1 — cycles `dut_reset` stays high after `resetn` deasserts or after `restart`; must be ≥1.
- `TRIG_CYCLE`, 10 — run-cycle index at which `trig` pulses.
- `CHECK_CYCLE`, 20 — run-cycle index at which `check` pulses; must be ≥ `TRIG_CYCLE`.
- `HANG_CYCLES`, 8 — number of consecutive run cycles without a retire that sets `stall`; must be ≥1.
- `CNT_W`, 8 — width of `cycle`, `retired` and the internal stall counter; must hold `CHECK_CYCLE` and `HANG_CYCLES`.

Ports:
- `clock` in 1 — single clock; all state is on the rising edge.
- `resetn` in 1 — asynchronous, active-low reset.
- `restart` in 1 — synchronous request to rerun the sequence; priority over all other inputs.
- `rvfi_valid` in NRET — per-channel retire strobes from the DUT.
- `dut_reset` out 1 — active-high reset to the DUT and checkers.
- `trig` out 1 — one-cycle trigger strobe.
- `check` out 1 — one-cycle check strobe.
- `stall` out 1 — sticky watchdog flag.
- `done` out 1 — sequence complete; sticky.
- `cycle` out CNT_W — current run-cycle index.
- `retired` out CNT_W — saturating count of retire events.

## Operation
- States: `S_RESET`, `S_RUN`, `S_DONE`. All outputs are registered.
- **S_RESET:** `dut_reset`=1. A down-counter loads `RESET_CYCLES-1`. When it reaches 0, the next state is `S_RUN`. `cycle`, `retired`, the stall counter, `stall` and `done` are held at 0.
- **S_RUN:** `dut_reset`=0.
  - `cycle` is 0 in the first run cycle and increments by 1 per cycle.
  - `trig`=1 exactly when `cycle`==`TRIG_CYCLE`. `check`=1 exactly when `cycle`==`CHECK_CYCLE`. If the two parameters are equal, both pulse in the same cycle.
  - After the `check` cycle, the next state is `S_DONE`.
- **S_DONE:**
  - `done`=1; `trig`=0 and `check`=0.
  - `cycle` freezes at `CHECK_CYCLE`+1.
  - `retired` and `stall` freeze.
  - `rvfi_valid` is ignored.
- **Retire count:** each run cycle, `retired` gains the popcount of `rvfi_valid` (0..NRET). The sum is computed at CNT_W+1 bits and `retired` saturates at 2^CNT_W−1.
- **Watchdog:**
  - The stall counter resets to 0 in any run cycle where any bit of `rvfi_valid` is set; otherwise it increments, saturating at `HANG_CYCLES`.
  - `stall` goes high in the cycle after the counter reaches `HANG_CYCLES`.
  - `stall` stays high until `restart` or reset. A later retire does not clear it.
- `rvfi_valid` is ignored whenever `dut_reset`=1.
- **restart:** on an edge with `restart`=1, the block enters `S_RESET` from any state. It reloads the reset counter and clears `cycle`, `retired`, the stall counter, `stall` and `done`.
- **resetn low:** asynchronously forces `S_RESET`, `dut_reset`=1, and all other outputs to 0. The reset counter is loaded with `RESET_CYCLES-1`.

## Timing
- **Reset values:**
  - `dut_reset`=1.
  - `trig`, `check`, `stall` and `done` are 0.
  - `cycle` and `retired` are 0.
- After `resetn` rises, `dut_reset` is high for exactly `RESET_CYCLES` clock cycles. The first cycle with `dut_reset`=0 has `cycle`=0.
- **Output latencies, counted from the first run cycle:**
  - `trig` follows by `TRIG_CYCLE` cycles.
  - `check` follows by `CHECK_CYCLE` cycles.
  - `done` rises in the cycle after `check`.
- A retire in run cycle n is visible in `retired` at cycle n+1.
- **restart:** sampled at edge e. `dut_reset` is 1 from cycle e+1 for `RESET_CYCLES` cycles. A simultaneous `trig`/`check` condition at edge e is suppressed.
- **Mid-sequence:** `restart` or `resetn` assertion mid-sequence discards all progress; no partial `check` pulse is produced.

## Test plan
All scenarios use defaults overridden to NRET=2, RESET_CYCLES=2, TRIG_CYCLE=4, CHECK_CYCLE=10, HANG_CYCLES=5, CNT_W=8, unless a scenario says otherwise.
- **Release, no retires:** release `resetn` with `rvfi_valid`=0 → `dut_reset` high for 2 cycles; `trig` at cycle 4; `stall` rises at cycle 5; `check` at cycle 10; `done`=1 with `cycle`=11; `retired`=0.
- **Full retire rate:** `rvfi_valid`=2'b11 every cycle → `retired`=20 at cycle 10; `stall` never rises; frozen `retired`=22 in `S_DONE`.
- **Single retire:** `rvfi_valid`=2'b01 only at cycle 3 → `stall` rises at cycle 9; a retire at cycle 9 leaves `stall` high; `retired`=1.
- **restart mid-run:** `restart` pulse at cycle 6 after `stall` set → next cycle `dut_reset`=1 and all counters/flags 0; rerun places `trig` 2+4 cycles later; no `check` from the first run.
- **Async reset:** drop `resetn` between edges at cycle 7 → outputs hit reset values immediately, without waiting for a clock edge; after release, the sequence restarts from `dut_reset` high for 2 cycles.
- **Saturation:** CNT_W=4, CHECK_CYCLE=12, HANG_CYCLES=3, `rvfi_valid`=2'b11 continuously → `retired` saturates at 15 and does not wrap.

Source files
------------

// File: rtl/rvfi_check_sequencer.sv
// rvfi_check_sequencer: sequences DUT reset and trig/check strobes for a riscv-formal harness,
// with a retire watchdog and a saturating retire counter on the RVFI valid bus.
module rvfi_check_sequencer #(
    parameter int NRET         = 1,
    parameter int RESET_CYCLES = 1,
    parameter int TRIG_CYCLE   = 10,
    parameter int CHECK_CYCLE  = 20,
    parameter int HANG_CYCLES  = 8,
    parameter int CNT_W        = 8
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             restart,
    input  logic [NRET-1:0]  rvfi_valid,
    output logic             dut_reset,
    output logic             trig,
    output logic             check,
    output logic             stall,
    output logic             done,
    output logic [CNT_W-1:0] cycle,
    output logic [CNT_W-1:0] retired
);
    typedef enum logic [1:0] {S_RESET, S_RUN, S_DONE} state_t;

    localparam int RW = RESET_CYCLES > 1 ? $clog2(RESET_CYCLES) : 1;
    localparam logic [RW-1:0] RST_LOAD = RW'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] TRIG_AT  = CNT_W'(TRIG_CYCLE);
    localparam logic [CNT_W-1:0] CHECK_AT = CNT_W'(CHECK_CYCLE);
    localparam logic [CNT_W-1:0] HANG_AT  = CNT_W'(HANG_CYCLES);

    state_t state, state_d;
    logic [RW-1:0] rst_cnt, rst_cnt_d;
    logic [CNT_W-1:0] hang_cnt, hang_cnt_d, cycle_d, retired_d, hang_inc;
    logic [CNT_W:0] pop, sum;
    logic run, trig_d, check_d, stall_d, done_d, dut_reset_d;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= S_RESET;
        else state <= state_d;
    end

    always_comb begin
        state_d = restart ? S_RESET :
                  (state == S_RESET && rst_cnt == '0) ? S_RUN :
                  (state == S_RUN && cycle == CHECK_AT) ? S_DONE : state;
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < NRET; i++) pop = pop + (CNT_W+1)'(rvfi_valid[i]);
    end

    // Retires and the watchdog only advance in run cycles not cancelled by restart
    always_comb begin
        run         = state == S_RUN && !restart;
        sum         = {1'b0, retired} + pop;
        hang_inc    = hang_cnt == HANG_AT ? hang_cnt : hang_cnt + CNT_W'(1);
        dut_reset_d = state_d == S_RESET;
        rst_cnt_d   = (restart || state != S_RESET) ? RST_LOAD : rst_cnt - RW'(1);
        cycle_d     = restart ? '0 : run ? cycle + CNT_W'(1) : cycle;
        trig_d      = state_d == S_RUN && cycle_d == TRIG_AT;
        check_d     = state_d == S_RUN && cycle_d == CHECK_AT;
        retired_d   = restart ? '0 : run ? (sum[CNT_W] ? '1 : sum[CNT_W-1:0]) : retired;
        hang_cnt_d  = restart ? '0 : run ? (|rvfi_valid ? '0 : hang_inc) : hang_cnt;
        stall_d     = !restart && (stall || (run && hang_cnt_d == HANG_AT));
        done_d      = state_d == S_DONE;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rst_cnt   <= RST_LOAD;
            dut_reset <= 1'b1;
            trig      <= 1'b0;
            check     <= 1'b0;
            stall     <= 1'b0;
            done      <= 1'b0;
            cycle     <= '0;
            retired   <= '0;
            hang_cnt  <= '0;
        end else begin
            rst_cnt   <= rst_cnt_d;
            dut_reset <= dut_reset_d;
            trig      <= trig_d;
            check     <= check_d;
            stall     <= stall_d;
            done      <= done_d;
            cycle     <= cycle_d;
            retired   <= retired_d;
            hang_cnt  <= hang_cnt_d;
        end
    end
endmodule
